// File: rtl/synth_cfg_pkg.sv
// Shared types for the synth configuration pin protocol (initiator and receiver).
package synth_cfg_pkg;

   localparam int CFG_WORDS     = 8;
   localparam int CFG_ADDR_BITS = 3;

   localparam logic LANE_LO = 1'b0;
   localparam logic LANE_HI = 1'b1;

   typedef struct packed {
      logic [CFG_ADDR_BITS-1:0] addr;
      logic [15:0]              data;
      logic [1:0]               mask;
   } cfg_req_t;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SETUP = 2'd1,
      ST_HIGH  = 2'd2,
      ST_LOW   = 2'd3
   } cfg_state_t;

   function automatic logic [7:0] lane_byte(input logic [15:0] data, input logic lane);
      lane_byte = (lane == LANE_HI) ? data[15:8] : data[7:0];
   endfunction

   // Low lane always goes first when it is enabled.
   function automatic logic first_lane(input logic [1:0] mask);
      first_lane = mask[0] ? LANE_LO : LANE_HI;
   endfunction

endpackage

// File: rtl/synth_cfg_writer_if.sv
// Word-write request port: valid/ready handshake carrying address, data and byte mask.
interface synth_cfg_writer_if;
   import synth_cfg_pkg::*;

   logic                     req_valid;
   logic                     req_ready;
   logic [CFG_ADDR_BITS-1:0] req_addr;
   logic [15:0]              req_data;
   logic [1:0]               req_mask;

   modport master (output req_valid, req_addr, req_data, req_mask, input req_ready);
   modport slave  (input req_valid, req_addr, req_data, req_mask, output req_ready);

endinterface

// File: rtl/synth_cfg_fifo.sv
// Synchronous FIFO of write requests with full/empty flags and fill level.
module synth_cfg_fifo
   import synth_cfg_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 push,
   input  cfg_req_t             wr_data,
   input  logic                 pop,
   output cfg_req_t             rd_data,
   output logic                 full,
   output logic                 empty,
   output logic [$clog2(DEPTH):0] level
);
   localparam int PTR_W = $clog2(DEPTH);

   cfg_req_t           mem_r [DEPTH];
   logic [PTR_W-1:0]   wr_ptr_r;
   logic [PTR_W-1:0]   rd_ptr_r;
   logic [PTR_W:0]     level_r;
   logic               push_s;
   logic               pop_s;

   assign push_s  = push & ~full;
   assign pop_s   = pop & ~empty;
   assign full    = (level_r == (PTR_W+1)'(DEPTH));
   assign empty   = (level_r == {(PTR_W+1){1'b0}});
   assign level   = level_r;
   assign rd_data = mem_r[rd_ptr_r];

   // Pointers and level; a simultaneous push and pop leaves the level unchanged.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_r <= {PTR_W{1'b0}};
         rd_ptr_r <= {PTR_W{1'b0}};
         level_r  <= {(PTR_W+1){1'b0}};
      end else begin
         if (push_s) wr_ptr_r <= wr_ptr_r + PTR_W'(1);
         if (pop_s)  rd_ptr_r <= rd_ptr_r + PTR_W'(1);
         case ({push_s, pop_s})
            2'b10:   level_r <= level_r + (PTR_W+1)'(1);
            2'b01:   level_r <= level_r - (PTR_W+1)'(1);
            default: level_r <= level_r;
         endcase
      end
   end

   // Storage array.
   always_ff @(posedge clk) begin
      if (push_s) mem_r[wr_ptr_r] <= wr_data;
   end

endmodule

// File: rtl/synth_cfg_writer.sv
// Buffers 16-bit config writes and serializes them into strobed byte transfers on the cfg pins.
module synth_cfg_writer
   import synth_cfg_pkg::*;
#(
   parameter int FIFO_DEPTH   = 4,
   parameter int SETUP_CYCLES = 2,
   parameter int HIGH_CYCLES  = 8,
   parameter int LOW_CYCLES   = 4
) (
   input  logic                        clk,
   input  logic                        rst_n,
   synth_cfg_writer_if.slave           req,
   output logic [7:0]                  cfg_data_out,
   output logic [3:0]                  cfg_addr_out,
   output logic                        cfg_strobe_out,
   output logic                        busy,
   output logic [$clog2(FIFO_DEPTH):0] fifo_level
);
   localparam int MAX_CYC = (HIGH_CYCLES > SETUP_CYCLES) ?
                            ((HIGH_CYCLES > LOW_CYCLES) ? HIGH_CYCLES : LOW_CYCLES) :
                            ((SETUP_CYCLES > LOW_CYCLES) ? SETUP_CYCLES : LOW_CYCLES);
   localparam int CNT_W   = $clog2(MAX_CYC);

   cfg_state_t state_r, state_nxt_s;
   logic [CNT_W-1:0] cnt_r, cnt_nxt_s;
   cfg_req_t   hold_r, hold_nxt_s;
   logic       lane_r, lane_nxt_s;
   logic [7:0] data_r, data_nxt_s;
   logic [3:0] addr_r, addr_nxt_s;
   logic       strobe_r, strobe_nxt_s;
   logic       run_r;
   logic       pop_s, full_s, empty_s, push_s;
   cfg_req_t   head_s, wr_s;

   assign wr_s          = '{addr: req.req_addr, data: req.req_data, mask: req.req_mask};
   assign req.req_ready = run_r & ~full_s;
   assign push_s        = req.req_valid & req.req_ready;

   synth_cfg_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .push    (push_s),
      .wr_data (wr_s),
      .pop     (pop_s),
      .rd_data (head_s),
      .full    (full_s),
      .empty   (empty_s),
      .level   (fifo_level)
   );

   assign cfg_data_out   = data_r;
   assign cfg_addr_out   = addr_r;
   assign cfg_strobe_out = strobe_r;
   assign busy           = ~empty_s | (state_r != ST_IDLE);

   // Serializer next-state: pins change only on entry to SETUP.
   always_comb begin
      state_nxt_s  = state_r;
      cnt_nxt_s    = cnt_r;
      hold_nxt_s   = hold_r;
      lane_nxt_s   = lane_r;
      data_nxt_s   = data_r;
      addr_nxt_s   = addr_r;
      strobe_nxt_s = strobe_r;
      pop_s        = 1'b0;
      case (state_r)
         ST_IDLE: begin
            strobe_nxt_s = 1'b0;
            if (!empty_s) begin
               pop_s      = 1'b1;
               hold_nxt_s = head_s;
               if (head_s.mask != 2'b00) begin
                  lane_nxt_s  = first_lane(head_s.mask);
                  data_nxt_s  = lane_byte(head_s.data, first_lane(head_s.mask));
                  addr_nxt_s  = {head_s.addr, first_lane(head_s.mask)};
                  cnt_nxt_s   = CNT_W'(SETUP_CYCLES - 1);
                  state_nxt_s = ST_SETUP;
               end else begin
                  state_nxt_s = ST_IDLE;
               end
            end else begin
               state_nxt_s = ST_IDLE;
            end
         end
         ST_SETUP: begin
            if (cnt_r == {CNT_W{1'b0}}) begin
               strobe_nxt_s = 1'b1;
               cnt_nxt_s    = CNT_W'(HIGH_CYCLES - 1);
               state_nxt_s  = ST_HIGH;
            end else begin
               cnt_nxt_s = cnt_r - CNT_W'(1);
            end
         end
         ST_HIGH: begin
            if (cnt_r == {CNT_W{1'b0}}) begin
               strobe_nxt_s = 1'b0;
               cnt_nxt_s    = CNT_W'(LOW_CYCLES - 1);
               state_nxt_s  = ST_LOW;
            end else begin
               cnt_nxt_s = cnt_r - CNT_W'(1);
            end
         end
         ST_LOW: begin
            if (cnt_r == {CNT_W{1'b0}}) begin
               if ((hold_r.mask == 2'b11) && (lane_r == LANE_LO)) begin
                  lane_nxt_s  = LANE_HI;
                  data_nxt_s  = lane_byte(hold_r.data, LANE_HI);
                  addr_nxt_s  = {hold_r.addr, LANE_HI};
                  cnt_nxt_s   = CNT_W'(SETUP_CYCLES - 1);
                  state_nxt_s = ST_SETUP;
               end else begin
                  state_nxt_s = ST_IDLE;
               end
            end else begin
               cnt_nxt_s = cnt_r - CNT_W'(1);
            end
         end
         default: begin
            strobe_nxt_s = 1'b0;
            state_nxt_s  = ST_IDLE;
         end
      endcase
   end

   // Serializer state and pin registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r  <= ST_IDLE;
         cnt_r    <= {CNT_W{1'b0}};
         hold_r   <= '0;
         lane_r   <= LANE_LO;
         data_r   <= 8'h00;
         addr_r   <= 4'h0;
         strobe_r <= 1'b0;
         run_r    <= 1'b0;
      end else begin
         state_r  <= state_nxt_s;
         cnt_r    <= cnt_nxt_s;
         hold_r   <= hold_nxt_s;
         lane_r   <= lane_nxt_s;
         data_r   <= data_nxt_s;
         addr_r   <= addr_nxt_s;
         strobe_r <= strobe_nxt_s;
         run_r    <= 1'b1;
      end
   end

endmodule

// File: tb/tb_synth_cfg_writer.sv
// Directed bench for synth_cfg_writer with a 2-flop-sync receiver model and pin monitors.
module tb_synth_cfg_writer;
   import synth_cfg_pkg::*;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [7:0] cfg_data_out;
   logic [3:0] cfg_addr_out;
   logic       cfg_strobe_out;
   logic       busy;
   logic [2:0] fifo_level;

   synth_cfg_writer_if req_if ();

   synth_cfg_writer u_dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .req            (req_if),
      .cfg_data_out   (cfg_data_out),
      .cfg_addr_out   (cfg_addr_out),
      .cfg_strobe_out (cfg_strobe_out),
      .busy           (busy),
      .fifo_level     (fifo_level)
   );

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Cycle counter: after posedge k, cyc == k.
   always @(posedge clk) cyc <= cyc + 1;

   // Receiver model: 2-flop strobe sync, edge detect, optional override stall.
   logic        rx_s1 = 1'b0, rx_s2 = 1'b0, rx_prev = 1'b0, rx_stall = 1'b0;
   int          rx_cnt = 0;
   logic [15:0] rx_cfg [CFG_WORDS];
   logic [11:0] rx_log [$];
   always @(posedge clk) begin
      rx_s1 <= cfg_strobe_out;
      rx_s2 <= rx_s1;
      if (!rx_stall) begin
         rx_prev <= rx_s2;
         if (rx_s2 && !rx_prev) begin
            rx_cnt <= rx_cnt + 1;
            rx_log.push_back({cfg_addr_out, cfg_data_out});
            if (cfg_addr_out[0]) rx_cfg[cfg_addr_out[3:1]][15:8] <= cfg_data_out;
            else                 rx_cfg[cfg_addr_out[3:1]][7:0]  <= cfg_data_out;
         end
      end
   end

   // Pin monitor: strobe edges, pin stability, strobe-in-idle, peak fill level.
   int         rise_q [$];
   int         fall_q [$];
   logic       str_prev = 1'b0;
   logic [11:0] pins_prev = 12'h000;
   int         last_fall = -100;
   int         viol = 0;
   int         lvl_max = 0;
   logic       mon_en = 1'b0;
   always @(negedge clk) begin
      str_prev  <= cfg_strobe_out;
      pins_prev <= {cfg_addr_out, cfg_data_out};
      if (cfg_strobe_out && !str_prev) rise_q.push_back(cyc);
      if (!cfg_strobe_out && str_prev) begin
         fall_q.push_back(cyc);
         last_fall <= cyc;
      end
      if (int'(fifo_level) > lvl_max) lvl_max <= int'(fifo_level);
      if (mon_en) begin
         if (({cfg_addr_out, cfg_data_out} != pins_prev) &&
             (cfg_strobe_out || str_prev || (cyc - last_fall) < 4)) viol <= viol + 1;
         if (cfg_strobe_out && !busy) viol <= viol + 1;
      end
   end

   function automatic int q_at(input int idx, input bit rises);
      if (rises) q_at = (idx < rise_q.size()) ? rise_q[idx] : -1000;
      else       q_at = (idx < fall_q.size()) ? fall_q[idx] : -1000;
   endfunction

   // Present one request; returns the cycle index of the accepting edge.
   task automatic send(input logic [2:0] a, input logic [15:0] d, input logic [1:0] m,
                       output int acc);
      int g = 0;
      @(negedge clk);
      req_if.req_valid = 1'b1;
      req_if.req_addr  = a;
      req_if.req_data  = d;
      req_if.req_mask  = m;
      while (!req_if.req_ready && g < 100) begin
         @(negedge clk);
         g++;
      end
      if (g >= 100) check("send_timeout", 32'd1, 32'd0);
      @(posedge clk);
      @(negedge clk);
      acc = cyc;
      req_if.req_valid = 1'b0;
   endtask

   task automatic wait_idle(input string tag);
      int g = 0;
      while (busy && g < 400) begin
         @(negedge clk);
         g++;
      end
      if (g >= 400) check(tag, 32'd1, 32'd0);
   endtask

   task automatic wait_cyc(input int t);
      while (cyc < t) @(negedge clk);
   endtask

   int n, r0, c0, b0, l0;
   logic [15:0] bdata [6];

   initial begin
      req_if.req_valid = 1'b0;
      req_if.req_addr  = 3'd0;
      req_if.req_data  = 16'h0000;
      req_if.req_mask  = 2'b00;

      // Reset state
      repeat (3) @(negedge clk);
      check("rst_strobe", {31'd0, cfg_strobe_out}, 32'd0);
      check("rst_pins", {20'd0, cfg_addr_out, cfg_data_out}, 32'd0);
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_level", {29'd0, fifo_level}, 32'd0);
      check("rst_ready", {31'd0, req_if.req_ready}, 32'd0);
      rst_n = 1'b1;
      @(negedge clk);
      check("ready_after_rst", {31'd0, req_if.req_ready}, 32'd1);
      mon_en = 1'b1;

      // Full-word write, both lanes
      r0 = rise_q.size(); c0 = rx_cnt;
      send(3'd3, 16'hA55A, 2'b11, n);
      wait_cyc(n + 1);
      check("A_pins_lo", {20'd0, cfg_addr_out, cfg_data_out}, {20'd0, 4'b0110, 8'h5A});
      check("A_strobe_setup", {31'd0, cfg_strobe_out}, 32'd0);
      wait_cyc(n + 15);
      check("A_pins_hi", {20'd0, cfg_addr_out, cfg_data_out}, {20'd0, 4'b0111, 8'hA5});
      wait_cyc(n + 28);
      check("A_busy_end", {31'd0, busy}, 32'd1);
      wait_cyc(n + 29);
      check("A_idle", {31'd0, busy}, 32'd0);
      check("A_rise1", q_at(r0, 1'b1) - n, 32'd3);
      check("A_high1", q_at(r0, 1'b0) - q_at(r0, 1'b1), 32'd8);
      check("A_rise2", q_at(r0 + 1, 1'b1) - q_at(r0, 1'b0), 32'd6);
      check("A_high2", q_at(r0 + 1, 1'b0) - q_at(r0 + 1, 1'b1), 32'd8);
      check("A_writes", rx_cnt - c0, 32'd2);
      check("A_cfg3", {16'd0, rx_cfg[3]}, 32'hA55A);

      // High lane only
      r0 = rise_q.size(); c0 = rx_cnt; l0 = rx_log.size();
      send(3'd5, 16'h1234, 2'b10, n);
      wait_cyc(n + 1);
      check("B_pins", {20'd0, cfg_addr_out, cfg_data_out}, {20'd0, 4'b1011, 8'h12});
      wait_cyc(n + 15);
      check("B_idle", {31'd0, busy}, 32'd0);
      check("B_pulses", rise_q.size() - r0, 32'd1);
      check("B_writes", rx_cnt - c0, 32'd1);
      check("B_log", (rx_log.size() > l0) ? {20'd0, rx_log[l0]} : 32'hDEAD, {20'd0, 12'hB12});

      // Empty mask is dropped
      r0 = rise_q.size();
      send(3'd4, 16'hFFFF, 2'b00, n);
      check("C_busy_queued", {31'd0, busy}, 32'd1);
      wait_cyc(n + 1);
      check("C_busy_clear", {31'd0, busy}, 32'd0);
      wait_cyc(n + 6);
      check("C_no_strobe", rise_q.size() - r0, 32'd0);
      check("C_pins_kept", {20'd0, cfg_addr_out, cfg_data_out}, {20'd0, 4'b1011, 8'h12});

      // Receiver stalls its edge detector for 5 cycles during HIGH
      c0 = rx_cnt;
      send(3'd2, 16'h00C3, 2'b01, n);
      wait_cyc(n + 4);
      rx_stall = 1'b1;
      repeat (5) @(negedge clk);
      rx_stall = 1'b0;
      wait_idle("E_timeout");
      repeat (4) @(negedge clk);
      check("E_once", rx_cnt - c0, 32'd1);
      check("E_cfg2_lo", {24'd0, rx_cfg[2][7:0]}, 32'hC3);

      // Burst of 6 with valid held
      b0 = rise_q.size(); l0 = rx_log.size(); lvl_max = 0;
      begin
         int idx = 0;
         int g = 0;
         logic saw_ready;
         logic saw_stall = 1'b0;
         @(negedge clk);
         while (idx < 6 && g < 300) begin
            bdata[idx] = 16'h1100 + 16'(idx) * 16'h0101;
            req_if.req_valid = 1'b1;
            req_if.req_addr  = 3'(idx);
            req_if.req_data  = bdata[idx];
            req_if.req_mask  = 2'b11;
            saw_ready = req_if.req_ready;
            if (!saw_ready) saw_stall = 1'b1;
            @(posedge clk);
            if (saw_ready) idx++;
            @(negedge clk);
            g++;
         end
         req_if.req_valid = 1'b0;
         check("D_all_accepted", 32'(idx), 32'd6);
         check("D_ready_dropped", {31'd0, saw_stall}, 32'd1);
      end
      wait_idle("D_timeout");
      repeat (4) @(negedge clk);
      check("D_level_max", 32'(lvl_max), 32'd4);
      check("D_log_size", rx_log.size() - l0, 32'd12);
      for (int i = 0; i < 6; i++) begin
         check($sformatf("D_lo%0d", i),
               (rx_log.size() > l0 + 2*i) ? {20'd0, rx_log[l0 + 2*i]} : 32'hDEAD,
               {20'd0, 3'(i), 1'b0, bdata[i][7:0]});
         check($sformatf("D_hi%0d", i),
               (rx_log.size() > l0 + 2*i + 1) ? {20'd0, rx_log[l0 + 2*i + 1]} : 32'hDEAD,
               {20'd0, 3'(i), 1'b1, bdata[i][15:8]});
      end
      check("D_gap", q_at(b0 + 2, 1'b1) - q_at(b0 + 1, 1'b0), 32'd7);

      // Reset during HIGH of the first lane with a second request queued
      send(3'd7, 16'hBEEF, 2'b11, n);
      send(3'd6, 16'h0011, 2'b01, n);
      begin
         int g = 0;
         while (!cfg_strobe_out && g < 50) begin
            @(negedge clk);
            g++;
         end
         check("F_reached_high", {31'd0, cfg_strobe_out}, 32'd1);
      end
      check("F_level_pre", {29'd0, fifo_level}, 32'd1);
      repeat (2) @(negedge clk);
      mon_en = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      check("F_strobe", {31'd0, cfg_strobe_out}, 32'd0);
      check("F_level", {29'd0, fifo_level}, 32'd0);
      check("F_busy", {31'd0, busy}, 32'd0);
      check("F_ready", {31'd0, req_if.req_ready}, 32'd0);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      mon_en = 1'b1;
      r0 = rise_q.size();
      send(3'd1, 16'h0077, 2'b01, n);
      wait_cyc(n + 14);
      check("F_busy_end", {31'd0, busy}, 32'd1);
      wait_cyc(n + 15);
      check("F_idle", {31'd0, busy}, 32'd0);
      check("F_rise", q_at(r0, 1'b1) - n, 32'd3);
      check("F_high", q_at(r0, 1'b0) - q_at(r0, 1'b1), 32'd8);
      repeat (4) @(negedge clk);
      check("F_cfg1_lo", {24'd0, rx_cfg[1][7:0]}, 32'h77);

      check("pin_rules", 32'(viol), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
